agc_instr_sequencer: RTL and testbench

- Instruction sequencer for the AGC simulator core.
- Owns the program counter Z and fetches 15-bit words from memory over a req/ack handshake.
- Latches each word into an instruction register (IR), absorbs EXTEND prefixes into an extracode flag, and dispatches decoded fields to the execution unit.
- Waits for execution completion, then applies any branch target before the next fetch.

---
 rtl/agc_instr_sequencer.sv | 167 ++++++++++++++++
 tb/tb_agc_instr_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/agc_instr_sequencer.sv
// AGC instruction sequencer: owns Z, fetches, absorbs EXTEND, dispatches.
// Optional fetch watchdog: define AGC_SEQ_FETCH_TIMEOUT_EN.
module agc_instr_sequencer #(
    parameter logic [11:0] RESET_VECTOR  = 12'o4000,
    parameter logic [14:0] EXTEND_WORD   = 15'o00006,
    parameter int          FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        mem_req,
    output logic [11:0] mem_addr,
    input  logic        mem_ack,
    input  logic [14:0] mem_rdata,
    output logic        dispatch_valid,
    output logic [14:0] ir,
    output logic [2:0]  opcode,
    output logic [1:0]  qc,
    output logic        pc_bit,
    output logic [11:0] addr12,
    output logic [9:0]  addr10,
    output logic        extend,
    input  logic        exec_done,
    input  logic        branch_valid,
    input  logic [11:0] branch_target,
    output logic [11:0] z,
    output logic        busy,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DISPATCH,
        S_EXEC
`ifdef AGC_SEQ_FETCH_TIMEOUT_EN
        ,
        S_HALT
`endif
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [11:0] z_d;
    logic [14:0] ir_d;
    logic        ext_d;

`ifdef AGC_SEQ_FETCH_TIMEOUT_EN
    localparam int CW = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(FETCH_TIMEOUT - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic          err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            z      <= RESET_VECTOR;
            ir     <= '0;
            extend <= 1'b0;
        end else begin
            state  <= state_d;
            z      <= z_d;
            ir     <= ir_d;
            extend <= ext_d;
        end
    end

`ifdef AGC_SEQ_FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            fetch_err <= 1'b0;
        end else begin
            cnt       <= cnt_d;
            fetch_err <= err_d;
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

    always_comb begin
        state_d = state;
        z_d     = z;
        ir_d    = ir;
        ext_d   = extend;
`ifdef AGC_SEQ_FETCH_TIMEOUT_EN
        cnt_d   = cnt;
        err_d   = fetch_err;
`endif
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
`ifdef AGC_SEQ_FETCH_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    z_d = z + 12'd1;
`ifdef AGC_SEQ_FETCH_TIMEOUT_EN
                    cnt_d = '0;
`endif
                    // EXTEND only marks the next word; keep fetching
                    if (mem_rdata == EXTEND_WORD) begin
                        ext_d = 1'b1;
                    end else begin
                        ir_d    = mem_rdata;
                        state_d = S_DISPATCH;
                    end
                end
`ifdef AGC_SEQ_FETCH_TIMEOUT_EN
                else if (cnt == TO_LAST) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
`endif
            end
            S_DISPATCH: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (exec_done) begin
                    ext_d = 1'b0;
                    if (branch_valid) begin
                        z_d = branch_target;
                    end
                    if (run) begin
                        state_d = S_FETCH;
`ifdef AGC_SEQ_FETCH_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
`ifdef AGC_SEQ_FETCH_TIMEOUT_EN
            S_HALT: begin
                state_d = S_HALT;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_req        = (state == S_FETCH);
    assign mem_addr       = z;
    assign dispatch_valid = (state == S_DISPATCH);
    assign busy           = (state != S_IDLE);

    assign opcode = ir[14:12];
    assign qc     = ir[11:10];
    assign pc_bit = ir[9];
    assign addr12 = ir[11:0];
    assign addr10 = ir[9:0];

endmodule

// File: tb/tb_agc_instr_sequencer.sv
// Directed bench for agc_instr_sequencer with a transaction-level model.
module tb_agc_instr_sequencer;

    localparam logic [14:0] EXT = 15'o00006;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_ack;
    logic [14:0] mem_rdata;
    logic        dispatch_valid;
    logic [14:0] ir;
    logic [2:0]  opcode;
    logic [1:0]  qc;
    logic        pc_bit;
    logic [11:0] addr12;
    logic [9:0]  addr10;
    logic        extend;
    logic        exec_done;
    logic        branch_valid;
    logic [11:0] branch_target;
    logic [11:0] z;
    logic        busy;
    logic        fetch_err;

    agc_instr_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .dispatch_valid(dispatch_valid),
        .ir            (ir),
        .opcode        (opcode),
        .qc            (qc),
        .pc_bit        (pc_bit),
        .addr12        (addr12),
        .addr10        (addr10),
        .extend        (extend),
        .exec_done     (exec_done),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .z             (z),
        .busy          (busy),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model of what the sequencer must be showing right now
    logic [11:0] exp_z;
    logic [14:0] exp_ir;
    logic        exp_ext;
    logic        exp_req;
    logic        exp_disp;
    logic        exp_busy;
    logic        chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0o expected %0o (t=%0t)",
                      nm, act, req, $time);
    endtask

    task automatic model_reset();
        exp_z    = 12'o4000;
        exp_ir   = '0;
        exp_ext  = 1'b0;
        exp_req  = 1'b0;
        exp_disp = 1'b0;
        exp_busy = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("z", {20'd0, z}, {20'd0, exp_z});
            chk("ir", {17'd0, ir}, {17'd0, exp_ir});
            chk("extend", {31'd0, extend}, {31'd0, exp_ext});
            chk("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
            if (exp_req)
                chk("mem_addr", {20'd0, mem_addr}, {20'd0, exp_z});
            chk("dispatch", {31'd0, dispatch_valid}, {31'd0, exp_disp});
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            chk("fetch_err", {31'd0, fetch_err}, 32'd0);
            chk("opcode", {29'd0, opcode}, {29'd0, exp_ir[14:12]});
            chk("qc", {30'd0, qc}, {30'd0, exp_ir[11:10]});
            chk("pc_bit", {31'd0, pc_bit}, {31'd0, exp_ir[9]});
            chk("addr12", {20'd0, addr12}, {20'd0, exp_ir[11:0]});
            chk("addr10", {22'd0, addr10}, {22'd0, exp_ir[9:0]});
        end
    end

    // All tasks start and end just after a falling edge
    task automatic start();
        run = 1'b1;
        @(posedge clk); #1;
        exp_req  = 1'b1;
        exp_busy = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_fetch(input logic [14:0] w, input int nwait);
        repeat (nwait) @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = w;
        @(posedge clk); #1;
        exp_z = exp_z + 12'd1;
        if (w == EXT) begin
            exp_ext = 1'b1;
        end else begin
            exp_ir   = w;
            exp_req  = 1'b0;
            exp_disp = 1'b1;
        end
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 15'o77777;
    endtask

    task automatic finish(input int noise, input logic bv,
                          input logic [11:0] tgt, input logic rn);
        if (exp_disp) begin
            @(posedge clk); #1;
            exp_disp = 1'b0;
            @(negedge clk);
        end
        for (int i = 0; i < noise; i++) begin
            branch_valid  = 1'b1;
            branch_target = 12'o5555;
            mem_ack       = 1'b1;
            mem_rdata     = 15'o11111;
            @(negedge clk);
        end
        mem_ack       = 1'b0;
        exec_done     = 1'b1;
        branch_valid  = bv;
        branch_target = tgt;
        run           = rn;
        @(posedge clk); #1;
        if (bv) exp_z = tgt;
        exp_ext  = 1'b0;
        exp_req  = rn;
        exp_busy = rn;
        @(negedge clk);
        exec_done    = 1'b0;
        branch_valid = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        run           = 1'b0;
        mem_ack       = 1'b0;
        mem_rdata     = '0;
        exec_done     = 1'b0;
        branch_valid  = 1'b0;
        branch_target = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_z", {20'd0, z}, 32'o4000);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ir", {17'd0, ir}, 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // first instruction: ack on the first request cycle
        start();
        chk("addr_4000", {20'd0, mem_addr}, 32'o4000);
        do_fetch(15'o62021, 0);
        chk("disp1", {31'd0, dispatch_valid}, 32'd1);
        chk("opc1", {29'd0, opcode}, 32'b110);
        // 62021: bits 11..9 are 010, so qc = 01 and pc_bit = 0
        chk("qc1", {30'd0, qc}, 32'b01);
        chk("pc1", {31'd0, pc_bit}, 32'd0);
        chk("a12_1", {20'd0, addr12}, 32'o2021);
        chk("a10_1", {22'd0, addr10}, 32'o0021);
        chk("ext1", {31'd0, extend}, 32'd0);
        chk("z1", {20'd0, z}, 32'o4001);
        finish(0, 1'b0, 12'o0, 1'b1);

        // EXTEND prefix then a real word
        chk("addr_4001", {20'd0, mem_addr}, 32'o4001);
        do_fetch(EXT, 0);
        chk("ext_nodisp", {31'd0, dispatch_valid}, 32'd0);
        chk("ext_addr", {20'd0, mem_addr}, 32'o4002);
        do_fetch(15'o10005, 1);
        chk("ext_disp", {31'd0, dispatch_valid}, 32'd1);
        chk("ext_ir", {17'd0, ir}, 32'o10005);
        chk("ext_flag", {31'd0, extend}, 32'd1);
        chk("ext_z", {20'd0, z}, 32'o4003);
        finish(3, 1'b1, 12'o1234, 1'b1);
        chk("ext_clr", {31'd0, extend}, 32'd0);
        chk("br_addr", {20'd0, mem_addr}, 32'o1234);

        // wrap of Z at the top of memory
        do_fetch(15'o30100, 2);
        finish(0, 1'b1, 12'o7777, 1'b1);
        chk("addr_7777", {20'd0, mem_addr}, 32'o7777);
        do_fetch(15'o04000, 0);
        chk("wrap_z", {20'd0, z}, 32'o0000);
        finish(1, 1'b0, 12'o0, 1'b1);
        chk("wrap_addr", {20'd0, mem_addr}, 32'o0000);

        // back-to-back EXTENDs then stop at the boundary
        do_fetch(EXT, 0);
        do_fetch(EXT, 1);
        do_fetch(15'o54321, 0);
        chk("ext2_flag", {31'd0, extend}, 32'd1);
        chk("ext2_z", {20'd0, z}, 32'o0003);
        finish(2, 1'b0, 12'o0, 1'b0);
        chk("stop_req", {31'd0, mem_req}, 32'd0);
        chk("stop_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            mem_ack   = 1'b1;
            mem_rdata = 15'o22222;
            @(negedge clk);
        end
        mem_ack = 1'b0;

        // asynchronous reset while a fetch is pending
        start();
        @(negedge clk);
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        run    = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_z", {20'd0, z}, 32'o4000);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // fetch with no ack at all
        start();
        chk_en = 1'b0;
        repeat (14) @(negedge clk);
        chk("to_req14", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
`ifdef AGC_SEQ_FETCH_TIMEOUT_EN
        chk("to_req", {31'd0, mem_req}, 32'd0);
        chk("to_err", {31'd0, fetch_err}, 32'd1);
        chk("to_busy", {31'd0, busy}, 32'd1);
        repeat (5) @(negedge clk);
        chk("halt_req", {31'd0, mem_req}, 32'd0);
        chk("halt_err", {31'd0, fetch_err}, 32'd1);
`else
        chk("to_req", {31'd0, mem_req}, 32'd1);
        chk("to_err", {31'd0, fetch_err}, 32'd0);
        repeat (5) @(negedge clk);
        chk("wait_req", {31'd0, mem_req}, 32'd1);
        chk("wait_addr", {20'd0, mem_addr}, 32'o4000);
`endif
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        chk("fin_err", {31'd0, fetch_err}, 32'd0);
        chk("fin_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
